fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised successor to the pipeline's fetch stage: owns the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers responses in a DEPTH-entry queue that feeds Decode.
- Decode stalls by holding the queue head.
- Execute redirects (branch/jump) flush the queue and discard in-flight responses.
- Sits between the PC/branch logic and the IF/ID boundary; tolerates variable imem latency.

Parameters:
- XLEN, 32, PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, fetch-queue entries and maximum credits (≥2).
- RESET_PC, 32'h0040_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  Execute redirect request.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and treated as 0.
- stall_d  in  1  Decode stall; head is not popped.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (current PC).
- imem_req_ready  in  1  imem accepts the request.
- imem_rsp_valid  in  1  in-order response valid; no backpressure.
- imem_rsp_data  in  ILEN  fetched instruction.
- instr_valid_d  out  1  queue head valid.
- instr_d  out  ILEN  queue head instruction.
- pc_d  out  XLEN  PC of the head instruction.
- queue_count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, rsp_pc=RESET_PC.
  - Queue empty, outstanding=0, discard=0.
  - Outputs: instr_valid_d=0, queue_count=0, imem_req_valid=0.
  - Reset mid-operation drops everything; responses arriving after reset for pre-reset requests are a protocol error and are not covered.
- Credit rule: imem_req_valid = rst_n && !redirect_valid && (queue_count + outstanding − discard < DEPTH).
  - The queue can never overflow.
  - A response arriving when the queue is full is an assertion failure.
- Request accept (valid && ready):
  - pc ← pc+4, wrapping modulo 2^XLEN.
  - outstanding++.
  - imem_req_addr holds stable while valid && !ready.
- Response:
  - Every response decrements outstanding.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise: push {imem_rsp_data, rsp_pc} and rsp_pc ← rsp_pc+4.
- Pop: when instr_valid_d && !stall_d, the head is removed at the edge.
  - Push and pop in the same cycle keep queue_count unchanged, including at count=DEPTH.
- Latency:
  - A request accepted at cycle N with response at N+k gives instr_valid_d at N+k+1 (queue is registered, no bypass).
  - Minimum fetch-to-decode latency is 2 cycles with k=1.
- Redirect (redirect_valid=1), which takes priority over pop, push and request:
  - Queue flushed; queue_count=0 next cycle.
  - pc ← rsp_pc ← {redirect_pc[XLEN−1:2],2'b00}.
  - discard ← outstanding − (imem_rsp_valid?1:0).
  - A response in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; discard is recomputed each cycle.
- Queue is a circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH. DEPTH need not be a power of two: pointers wrap explicitly at DEPTH−1.
- Outputs instr_d and pc_d are don't-care when instr_valid_d=0. The bench must not check them then.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN/ILEN defaults, RESET_PC, PC_INC=4.
  - Typedef fetch_entry_t {instr, pc}.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH) with push, pop, flush, count, full and empty, instantiated with fetch_entry_t.
- PC, credit and discard logic stay in fetch_queue_stage.

Test Plan:
1. Reset → instr_valid_d=0 and queue_count=0. First request has imem_req_addr=0x0040_0000. With ready=1 every cycle, addresses 0x00400000, 0x00400004, 0x00400008 are issued on consecutive cycles.
2. 1-cycle imem, stall_d=0 → instr_valid_d first high 2 cycles after the first accept, pc_d=0x00400000; pc_d then advances by 4 each cycle with no bubbles.
3. stall_d=1 held for 10 cycles, DEPTH=4 → queue_count saturates at 4 and imem_req_valid drops to 0. Release stall_d → head pc_d=0x00400000 is popped first and order is preserved.
4. Redirect to 0x00400103 with 2 requests outstanding → queue_count=0 next cycle. The next 2 responses are dropped. First new instr_d has pc_d=0x00400100.
5. imem_req_ready=0 for 5 cycles → imem_req_addr is stable and outstanding is unchanged. Redirect during the wait changes the address to the new target in the following cycle.
6. rst_n=0 pulsed mid-stream with the queue at 3 entries → next cycle instr_valid_d=0, queue_count=0, and the first request address is 0x00400000 again.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch-pipeline widths, reset PC and fetch-queue entry type
package pipe_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic [ILEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered circular-buffer FIFO with flush; DEPTH need not be a power of two
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths index only valid slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - PC owner issuing credit-limited imem fetches into a decode-facing queue
module fetch_queue_stage
  import pipe_pkg::*;
#(
  parameter int                XLEN     = XLEN_DEFAULT,
  parameter int                ILEN     = ILEN_DEFAULT,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT,
  localparam int               CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid_d,
  output logic [ILEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [CW-1:0]   queue_count
);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW:0]     in_flight;
  logic            req_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};

  // Discarded responses still occupy imem but never land in the queue, so they earn back credit.
  assign in_flight      = {1'b0, queue_count} + {1'b0, outstanding} - {1'b0, discard};
  assign imem_req_valid = rst_n && !redirect_valid && (in_flight < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep   = imem_rsp_valid && (discard == '0);
  assign push       = rsp_keep && !redirect_valid;
  assign pop        = instr_valid_d && !stall_d && !redirect_valid;
  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

  assign instr_valid_d = !empty;
  assign instr_d       = head.instr;
  assign pc_d          = head.pc;

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .pop_data (head),
    .count    (queue_count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // A response landing this cycle is the oldest in flight and is dropped here, not counted.
      pc          <= redirect_target;
      rsp_pc      <= redirect_target;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      discard     <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc <= pc + XLEN'(PC_INC);
      if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(PC_INC);
      else if (imem_rsp_valid) discard <= discard - 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid) assert (!(rsp_keep && full && !pop));
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed table, corner sequences and random run against a queue-level model
module tb_fetch_queue_stage;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n, redirect_valid, stall_d, imem_req_ready, imem_rsp_valid;
  logic [31:0]   redirect_pc, imem_rsp_data;
  logic          imem_req_valid, instr_valid_d;
  logic [31:0]   imem_req_addr, instr_d, pc_d;
  logic [CW-1:0] queue_count;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall_d       (stall_d),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid_d (instr_valid_d),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .queue_count   (queue_count)
  );

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    logic r, st, c_req, e_req;
    logic [31:0] e_addr;
    logic c_q, e_valid;
    logic [31:0] e_pc;
    int e_count;
  } vec_t;

  req_t  m_inflight[$];
  ent_t  m_q[$];
  pend_t imem_q[$];
  vec_t  vt[$];
  logic [31:0] m_pc;
  bit    m_known = 0;
  int    cyc = 0, checks = 0, errors = 0, lat = 1;
  logic  s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;
  int    s_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model at negedge, advance model at posedge.
  task automatic step(input logic r, input logic red, input logic [31:0] rpc,
                      input logic st, input logic rdy);
    int   live;
    logic exp_req;
    req_t rq;
    rst_n = r; redirect_valid = red; redirect_pc = rpc; stall_d = st; imem_req_ready = rdy;
    if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(imem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    s_req = imem_req_valid; s_addr = imem_req_addr; s_valid = instr_valid_d;
    s_instr = instr_d; s_pc = pc_d; s_count = int'(queue_count);
    live = 0;
    foreach (m_inflight[i]) if (!m_inflight[i].stale) live++;
    exp_req = r && !red && (m_q.size() + live < DEPTH);
    check("model_req_valid", {31'b0, s_req}, {31'b0, exp_req});
    if (exp_req) check("model_req_addr", s_addr, m_pc);
    if (m_known && r) begin
      check("model_queue_count", 32'(s_count), 32'(m_q.size()));
      check("model_instr_valid", {31'b0, s_valid}, {31'b0, m_q.size() > 0});
      if (m_q.size() > 0 && s_valid) begin
        check("model_pc_d", s_pc, m_q[0].pc);
        check("model_instr_d", s_instr, m_q[0].instr);
      end
    end
    @(posedge clk);
    if (imem_rsp_valid) void'(imem_q.pop_front());
    if (s_req && rdy && r) imem_q.push_back('{addr: s_addr, due: cyc + lat});
    if (!r) begin
      imem_q.delete();
      m_known = 1;
      m_pc = 32'h0040_0000;
      m_q.delete();
      m_inflight.delete();
    end else if (red) begin
      if (imem_rsp_valid && m_inflight.size() > 0) void'(m_inflight.pop_front());
      foreach (m_inflight[i]) m_inflight[i].stale = 1;
      m_q.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (imem_rsp_valid && m_inflight.size() > 0) begin
        rq = m_inflight.pop_front();
        if (!rq.stale) m_q.push_back('{instr: imem_rsp_data, pc: rq.addr});
      end
      if (exp_req && rdy) begin
        m_inflight.push_back('{addr: m_pc, stale: 0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic vec_t mk(logic r, logic st, logic c_req, logic e_req, logic [31:0] e_addr,
                              logic c_q, logic e_valid, logic [31:0] e_pc, int e_count);
    vec_t v;
    v.r = r; v.st = st; v.c_req = c_req; v.e_req = e_req; v.e_addr = e_addr;
    v.c_q = c_q; v.e_valid = e_valid; v.e_pc = e_pc; v.e_count = e_count;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    logic [31:0] held;

    // Reset, 1-cycle imem streaming, then a 10-cycle stall that saturates the queue.
    vt.push_back(mk(0, 0, 1, 0, 0,            0, 0, 0,            0));
    vt.push_back(mk(0, 0, 1, 0, 0,            1, 0, 0,            0));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0000, 1, 0, 0,            0));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0004, 1, 0, 0,            0));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0008, 1, 1, 32'h0040_0000, 1));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_000c, 1, 1, 32'h0040_0004, 1));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0010, 1, 1, 32'h0040_0008, 1));
    vt.push_back(mk(1, 1, 1, 1, 32'h0040_0014, 1, 1, 32'h0040_000c, 1));
    vt.push_back(mk(1, 1, 1, 1, 32'h0040_0018, 1, 1, 32'h0040_000c, 2));
    vt.push_back(mk(1, 1, 1, 0, 0,            1, 1, 32'h0040_000c, 3));
    for (int i = 0; i < 7; i++) vt.push_back(mk(1, 1, 1, 0, 0, 1, 1, 32'h0040_000c, 4));
    vt.push_back(mk(1, 0, 1, 0, 0,            1, 1, 32'h0040_000c, 4));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_001c, 1, 1, 32'h0040_0010, 3));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0020, 1, 1, 32'h0040_0014, 2));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0024, 1, 1, 32'h0040_0018, 2));
    vt.push_back(mk(1, 0, 1, 1, 32'h0040_0028, 1, 1, 32'h0040_001c, 2));

    lat = 1;
    foreach (vt[i]) begin
      step(vt[i].r, 1'b0, 32'h0, vt[i].st, 1'b1);
      if (vt[i].c_req) check($sformatf("tbl%0d_req_valid", i), {31'b0, s_req}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) check($sformatf("tbl%0d_req_addr", i), s_addr, vt[i].e_addr);
      if (vt[i].c_q) begin
        check($sformatf("tbl%0d_instr_valid", i), {31'b0, s_valid}, {31'b0, vt[i].e_valid});
        check($sformatf("tbl%0d_queue_count", i), 32'(s_count), 32'(vt[i].e_count));
        if (vt[i].e_valid) begin
          check($sformatf("tbl%0d_pc_d", i), s_pc, vt[i].e_pc);
          check($sformatf("tbl%0d_instr_d", i), s_instr, mem_word(vt[i].e_pc));
        end
      end
    end

    // Redirect with two requests in flight: both stale responses must be dropped.
    lat = 3;
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 1, 32'h0040_0103, 1, 1);
    step(1, 0, 0, 0, 1);
    check("redir_queue_count", 32'(s_count), 32'd0);
    check("redir_req_addr", s_addr, 32'h0040_0100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0, 1);
      if (s_valid) begin
        found = 1;
        check("redir_first_pc", s_pc, 32'h0040_0100);
        check("redir_first_instr", s_instr, mem_word(32'h0040_0100));
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL redir_first_pc: no instruction within 20 cycles, expected pc 00400100");
    end

    // imem not ready: address holds; a redirect mid-wait retargets it.
    lat = 2;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    held = s_addr;
    check("wait_addr_initial", held, 32'h0040_0000);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      check("wait_req_valid", {31'b0, s_req}, 32'd1);
      check("wait_addr_stable", s_addr, held);
    end
    step(1, 1, 32'h0040_0200, 0, 0);
    step(1, 0, 0, 0, 0);
    check("wait_redir_addr", s_addr, 32'h0040_0200);

    // Reset with three entries queued.
    lat = 1;
    step(0, 0, 0, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 1, 1);
      if (s_count == 3) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL rst_fill: queue_count never reached 3, last %0d", s_count);
    end
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    check("rst_instr_valid", {31'b0, s_valid}, 32'd0);
    check("rst_queue_count", 32'(s_count), 32'd0);
    check("rst_req_valid", {31'b0, s_req}, 32'd1);
    check("rst_req_addr", s_addr, 32'h0040_0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 24) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
